alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU datapath units, including shift_left_gate.
- Captures the selected ALU result together with upstream carry/overflow, and derives N/Z flags.
- Presents result and flags to the writeback/flag-register consumer over a valid/ready handshake.
- Two-entry skid buffer: full throughput, ready_o driven only from flops, in-order delivery.

Parameters:
WIDTH, 32, result bus width in bits (≥ 2)
CNTW, 16, width of the saturating delivered-result counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush; discards all held entries
valid_i  input  1  upstream result valid
ready_o  output  1  stage can accept a result this cycle
result_i  input  WIDTH  ALU result (e.g. shifter bus_o)
carry_i  input  1  upstream carry-out (last bit shifted out for shifts)
overflow_i  input  1  upstream signed overflow
valid_o  output  1  result_o/flags_o valid
ready_i  input  1  downstream accepts this cycle
result_o  output  WIDTH  held result
flags_o  output  4  {N,Z,C,V} for result_o
count_o  output  CNTW  number of delivered results, saturating

Behaviour:
- Reset is asynchronous and active-low on rst_n_i; single clock clk_i.
- Reset values: state EMPTY, valid_o=0, ready_o=1, result_o=0, flags_o=0, count_o=0; skid contents cleared.
- Handshakes:
  - in_fire = valid_i & ready_o
  - out_fire = valid_o & ready_i
- Flags are computed at capture time, from the value being written into an entry:
  - N = result_i[WIDTH-1]
  - Z = (result_i == 0)
  - C = carry_i
  - V = overflow_i
- Each entry holds {result, flags} atomically. Flags never change while an entry is held.
- Outputs: ready_o = (state != FULL); valid_o = (state != EMPTY). Both come from state flops; no combinational path from ready_i to ready_o.
- result_o/flags_o are driven from the main register. They are stable while valid_o=1 and ready_i=0.
- State machine (main reg M, skid reg S):
  - EMPTY: in_fire -> BUSY, M<=in.
  - BUSY:
    - in_fire & out_fire -> BUSY, M<=in.
    - in_fire & ~out_fire -> FULL, S<=in.
    - ~in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - FULL: no input accepted. out_fire -> BUSY, M<=S. Otherwise hold.
- Latency: a result accepted at edge k appears on result_o with valid_o=1 after edge k (1 cycle) when the stage is empty.
- Throughput: 1 result/cycle while ready_i=1.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated except by flush_i.
- Simultaneous events:
  - Full stage with ready_i=1: accepts nothing that cycle (ready_o=0). It returns to BUSY with ready_o=1 on the next cycle.
- flush_i=1 (synchronous, highest priority after reset):
  - Next state EMPTY.
  - Any in_fire that same cycle is discarded.
  - An out_fire in the flush cycle still counts; the downstream already sampled it.
- count_o increments by 1 on each out_fire and saturates at 2^CNTW-1 (no wrap). Only reset clears it; flush_i does not.
- Reset asserted mid-transfer: immediate return to reset values, independent of clk_i. Held entries are lost.
- valid_i may toggle freely; it has no meaning while ready_o=0 (upstream must hold its data).

Test Plan:
- Reset then idle, WIDTH=8 -> valid_o=0, ready_o=1, count_o=0. Then result_i=8'h80, carry_i=1, overflow_i=0, valid_i=1 for one cycle with ready_i=1 -> next cycle valid_o=1, result_o=8'h80, flags_o=4'b1010; count_o=1 after the following edge.
- Zero flag: result_i=8'h00, carry_i=0, overflow_i=1 -> flags_o=4'b0101.
- Back-to-back stream 8'h01..8'h10, valid_i=1, ready_i=1 every cycle -> outputs 8'h01..8'h10 in order, one per cycle, ready_o never deasserts, count_o=16.
- Backpressure:
  - Setup: ready_i=0, send 8'hA1, 8'hA2.
  - Required: ready_o=0 after the second accept; result_o holds 8'hA1.
  - Then ready_i=1: A1 then A2 delivered on consecutive cycles; ready_o=1 the cycle after A1 leaves.
  - Offer 8'hA3 while ready_o=0: A3 is not accepted.
- Flush while FULL, with valid_i=1 carrying 8'h55 in the flush cycle -> next cycle valid_o=0, ready_o=1, 8'h55 never appears, count_o unchanged.
- CNTW=2, deliver 5 results -> count_o reads 3 and stays 3. Assert rst_n_i low mid-cycle with the stage FULL -> valid_o=0, count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU output stage with N/Z/C/V flag capture,
// a two-entry skid buffer on a valid/ready handshake, and a delivered-result counter.
`default_nettype none

module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] result_i,
   input  logic             carry_i,
   input  logic             overflow_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o,
   output logic [CNTW-1:0]  count_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] main_res;
   logic [3:0]       main_flg;
   logic [WIDTH-1:0] skid_res;
   logic [3:0]       skid_flg;
   logic [CNTW-1:0]  count;
   logic [3:0]       in_flg;
   logic             in_fire;
   logic             out_fire;
   logic             load_m_in;
   logic             load_m_skid;
   logic             load_s_in;

   // Flags are frozen into the entry at capture so they can never drift from the result.
   assign in_flg   = {result_i[WIDTH-1], (result_i == '0), carry_i, overflow_i};
   assign ready_o  = (state != FULL);
   assign valid_o  = (state != EMPTY);
   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_o & ready_i;
   assign result_o = main_res;
   assign flags_o  = main_flg;
   assign count_o  = count;

   always_comb begin
      state_nxt   = state;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s_in   = 1'b0;
      if (flush_i) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = BUSY;
                  load_m_in = 1'b1;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  load_m_in = 1'b1;
               end else if (in_fire) begin
                  state_nxt = FULL;
                  load_s_in = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nxt   = BUSY;
                  load_m_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= EMPTY;
         main_res <= '0;
         main_flg <= '0;
         skid_res <= '0;
         skid_flg <= '0;
      end else begin
         state <= state_nxt;
         if (load_m_in) begin
            main_res <= result_i;
            main_flg <= in_flg;
         end else if (load_m_skid) begin
            main_res <= skid_res;
            main_flg <= skid_flg;
         end
         if (load_s_in) begin
            skid_res <= result_i;
            skid_flg <= in_flg;
         end
      end
   end

   // Counts every out_fire, including one in a flush cycle; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count <= '0;
      end else if (out_fire && (count != {CNTW{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: one WIDTH=8/CNTW=16 instance for the data path,
// one WIDTH=8/CNTW=2 instance for counter saturation and asynchronous reset.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_result_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, vin, rdy_o, cin, ovin, vout, rin;
   logic [7:0]  res_in, res_out;
   logic [3:0]  flg;
   logic [15:0] cnt;

   logic        b_rst_n, b_flush, b_vin, b_rdy_o, b_cin, b_ovin, b_vout, b_rin;
   logic [7:0]  b_res_in, b_res_out;
   logic [3:0]  b_flg;
   logic [1:0]  b_cnt;

   int n_cmp = 0;
   int n_err = 0;

   alu_result_stage #(.WIDTH(8), .CNTW(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rdy_o),
      .result_i(res_in), .carry_i(cin), .overflow_i(ovin), .valid_o(vout),
      .ready_i(rin), .result_o(res_out), .flags_o(flg), .count_o(cnt)
   );

   alu_result_stage #(.WIDTH(8), .CNTW(2)) dut_sat (
      .clk_i(clk), .rst_n_i(b_rst_n), .flush_i(b_flush), .valid_i(b_vin), .ready_o(b_rdy_o),
      .result_i(b_res_in), .carry_i(b_cin), .overflow_i(b_ovin), .valid_o(b_vout),
      .ready_i(b_rin), .result_o(b_res_out), .flags_o(b_flg), .count_o(b_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; vin = 1'b0; res_in = '0; cin = 1'b0; ovin = 1'b0; rin = 1'b0;
      b_rst_n = 1'b0; b_flush = 1'b0; b_vin = 1'b0; b_res_in = '0; b_cin = 1'b0; b_ovin = 1'b0;
      b_rin = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; b_rst_n = 1'b1;

      // Reset state
      chk("rst_valid", vout, 0);
      chk("rst_ready", rdy_o, 1);
      chk("rst_count", cnt, 0);
      chk("rst_result", res_out, 0);
      chk("rst_flags", flg, 0);

      // Negative result with carry
      res_in = 8'h80; cin = 1'b1; ovin = 1'b0; vin = 1'b1; rin = 1'b1;
      @(negedge clk);
      chk("t1_valid", vout, 1);
      chk("t1_result", res_out, 8'h80);
      chk("t1_flags", flg, 4'b1010);
      vin = 1'b0;
      @(negedge clk);
      chk("t1_count", cnt, 1);
      chk("t1_empty", vout, 0);

      // Zero result with overflow
      res_in = 8'h00; cin = 1'b0; ovin = 1'b1; vin = 1'b1;
      @(negedge clk);
      chk("t2_result", res_out, 8'h00);
      chk("t2_flags", flg, 4'b0101);
      vin = 1'b0; ovin = 1'b0;
      @(negedge clk);
      chk("t2_count", cnt, 2);

      // Back-to-back stream 01..10
      for (int i = 1; i <= 16; i++) begin
         res_in = 8'(i); vin = 1'b1;
         chk("st_ready", rdy_o, 1);
         if (i > 1) begin
            chk("st_valid", vout, 1);
            chk("st_result", res_out, 32'(i - 1));
         end
         @(negedge clk);
      end
      vin = 1'b0;
      chk("st_last", res_out, 8'h10);
      chk("st_ready_end", rdy_o, 1);
      @(negedge clk);
      chk("st_count", cnt, 2 + 16);
      chk("st_empty", vout, 0);

      // Backpressure into FULL
      rin = 1'b0; res_in = 8'hA1; vin = 1'b1;
      @(negedge clk);
      chk("bp_ready1", rdy_o, 1);
      chk("bp_hold1", res_out, 8'hA1);
      res_in = 8'hA2;
      @(negedge clk);
      chk("bp_ready0", rdy_o, 0);
      chk("bp_hold2", res_out, 8'hA1);
      chk("bp_flags", flg, 4'b1000);
      res_in = 8'hA3; rin = 1'b1;
      @(negedge clk);
      chk("bp_a2", res_out, 8'hA2);
      chk("bp_ready_back", rdy_o, 1);
      chk("bp_count1", cnt, 19);
      vin = 1'b0;
      @(negedge clk);
      chk("bp_no_a3", vout, 0);
      chk("bp_count2", cnt, 20);

      // Flush while FULL, 55 offered in the flush cycle
      rin = 1'b0; res_in = 8'hB1; vin = 1'b1;
      @(negedge clk);
      res_in = 8'hB2;
      @(negedge clk);
      chk("fl_full", rdy_o, 0);
      flush = 1'b1; res_in = 8'h55;
      @(negedge clk);
      flush = 1'b0; vin = 1'b0; rin = 1'b1;
      chk("fl_valid", vout, 0);
      chk("fl_ready", rdy_o, 1);
      chk("fl_count", cnt, 20);
      @(negedge clk);
      chk("fl_no55", vout, 0);
      chk("fl_count2", cnt, 20);

      // Flush in BUSY with simultaneous in_fire and out_fire
      res_in = 8'h66; vin = 1'b1;
      @(negedge clk);
      flush = 1'b1; res_in = 8'h77;
      @(negedge clk);
      flush = 1'b0; vin = 1'b0;
      chk("fb_valid", vout, 0);
      chk("fb_count", cnt, 21);

      // Saturating counter, CNTW=2
      b_rin = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         b_res_in = 8'(i); b_vin = 1'b1;
         @(negedge clk);
      end
      b_vin = 1'b0;
      @(negedge clk);
      chk("sat_count", b_cnt, 3);
      @(negedge clk);
      chk("sat_hold", b_cnt, 3);

      // Asynchronous reset mid-cycle while FULL
      b_rin = 1'b0; b_res_in = 8'hC1; b_vin = 1'b1;
      @(negedge clk);
      b_res_in = 8'hC2;
      @(negedge clk);
      chk("ar_full", b_rdy_o, 0);
      b_vin = 1'b0;
      #2 b_rst_n = 1'b0;
      #1;
      chk("ar_valid", b_vout, 0);
      chk("ar_count", b_cnt, 0);
      chk("ar_ready", b_rdy_o, 1);
      chk("ar_result", b_res_out, 0);
      @(negedge clk);
      b_rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
